// File: rtl/cmdfifo_gcd_responder_pkg.sv
// Shared constants for the command-FIFO GCD responder: opcode/response bytes and FSM encodings.
// Optional stats opcode is compiled in with CMDFIFO_STATS_EN.
package cmdfifo_pkg;

   typedef logic [7:0] byte_t;
   typedef logic [2:0] state_t;

   localparam byte_t OP_GCD   = 8'h47;
   localparam byte_t RSP_GCD  = 8'h67;
   localparam byte_t RSP_ERR  = 8'h3F;
   localparam byte_t OP_STAT  = 8'h53;
   localparam byte_t RSP_STAT = 8'h73;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_GET_X    = 3'd1;
   localparam state_t ST_GET_Y    = 3'd2;
   localparam state_t ST_CALC     = 3'd3;
   localparam state_t ST_SEND_HDR = 3'd4;
   localparam state_t ST_SEND_RES = 3'd5;
   localparam state_t ST_SEND_ERR = 3'd6;

endpackage

// File: rtl/cmdfifo_gcd_responder_if.sv
// Inbound/outbound FIFO handshake bundle between the command-FIFO link and the responder.
interface cmdfifo_gcd_responder_if;
   import cmdfifo_pkg::*;

   byte_t in_data;
   logic  in_empty;
   logic  in_rd;
   byte_t out_data;
   logic  out_full;
   logic  out_wr;
   logic  busy;

   modport master (
      output in_data, in_empty, out_full,
      input  in_rd, out_data, out_wr, busy
   );

   modport slave (
      input  in_data, in_empty, out_full,
      output in_rd, out_data, out_wr, busy
   );
endinterface

// File: rtl/cmdfifo_gcd_responder_gcd_core.sv
// Iterative subtract/swap GCD, one step per cycle; done is a single-cycle pulse with result valid.
module gcd_core #(
   parameter int N = 8
) (
   input  logic         clk_40mhz,
   input  logic         reset_i,
   input  logic         start,
   input  logic [N-1:0] x_in,
   input  logic [N-1:0] y_in,
   output logic         done,
   output logic [N-1:0] result
);

   logic [N-1:0] x_q, x_d, y_q, y_d, result_q, result_d;
   logic         run_q, run_d, done_q, done_d;

   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      run_d    = run_q;
      result_d = result_q;
      done_d   = 1'b0;
      if (start) begin
         x_d   = x_in;
         y_d   = y_in;
         run_d = 1'b1;
      end else if (run_q) begin
         if (y_q == '0) begin
            done_d   = 1'b1;
            result_d = x_q;
            run_d    = 1'b0;
         end else if (x_q >= y_q) begin
            x_d = x_q - y_q;
         end else begin
            x_d = y_q;
            y_d = x_q;
         end
      end
   end

   always_ff @(posedge clk_40mhz) begin
      if (reset_i) begin
         x_q      <= '0;
         y_q      <= '0;
         run_q    <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         x_q      <= x_d;
         y_q      <= y_d;
         run_q    <= run_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign done   = done_q;
   assign result = result_q;

endmodule

// File: rtl/cmdfifo_gcd_responder.sv
// Command-FIFO endpoint: parses 'G' x y, answers 'g' gcd; unknown opcodes get '?'.
// Define CMDFIFO_STATS_EN to add the 'S' opcode returning a count of completed GCD commands.
//
// state     | meaning
// IDLE      | waiting for a command byte
// GET_X     | fetching first operand
// GET_Y     | fetching second operand, kicks gcd_core
// CALC      | waiting for gcd_core done
// SEND_HDR  | pushing response header byte
// SEND_RES  | pushing result byte
// SEND_ERR  | pushing '?' for an unknown opcode
module cmdfifo_gcd_responder
   import cmdfifo_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                    clk_40mhz,
   input  logic                    reset_i,
   cmdfifo_gcd_responder_if.slave  bus
);

   state_t       state_q, state_d;
   logic [N-1:0] x_q, x_d, y_q, y_d;
   byte_t        res_q, res_d, hdr_q, hdr_d;
   logic         start_q, start_d;
   logic         core_done;
   logic [N-1:0] core_result;
`ifdef CMDFIFO_STATS_EN
   byte_t        cnt_q, cnt_d;
`endif

   gcd_core #(.N(N)) u_gcd_core (
      .clk_40mhz (clk_40mhz),
      .reset_i   (reset_i),
      .start     (start_q),
      .x_in      (x_q),
      .y_in      (y_q),
      .done      (core_done),
      .result    (core_result)
   );

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      res_d        = res_q;
      hdr_d        = hdr_q;
      start_d      = 1'b0;
      bus.in_rd    = 1'b0;
      bus.out_wr   = 1'b0;
      bus.out_data = 8'h00;
`ifdef CMDFIFO_STATS_EN
      cnt_d        = cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (!bus.in_empty) begin
               bus.in_rd = 1'b1;
               if (bus.in_data == OP_GCD) begin
                  state_d = ST_GET_X;
`ifdef CMDFIFO_STATS_EN
               end else if (bus.in_data == OP_STAT) begin
                  hdr_d   = RSP_STAT;
                  res_d   = cnt_q;
                  state_d = ST_SEND_HDR;
`endif
               end else begin
                  state_d = ST_SEND_ERR;
               end
            end
         end
         ST_GET_X: begin
            if (!bus.in_empty) begin
               bus.in_rd = 1'b1;
               x_d       = bus.in_data[N-1:0];
               state_d   = ST_GET_Y;
            end
         end
         ST_GET_Y: begin
            if (!bus.in_empty) begin
               bus.in_rd = 1'b1;
               y_d       = bus.in_data[N-1:0];
               start_d   = 1'b1;
               state_d   = ST_CALC;
            end
         end
         ST_CALC: begin
            if (core_done) begin
               res_d   = 8'(core_result);
               hdr_d   = RSP_GCD;
               state_d = ST_SEND_HDR;
`ifdef CMDFIFO_STATS_EN
               cnt_d   = cnt_q + 8'd1;
`endif
            end
         end
         // out_data is a pure function of state and held registers, so it stays put while stalled
         ST_SEND_HDR: begin
            bus.out_data = hdr_q;
            if (!bus.out_full) begin
               bus.out_wr = 1'b1;
               state_d    = ST_SEND_RES;
            end
         end
         ST_SEND_RES: begin
            bus.out_data = res_q;
            if (!bus.out_full) begin
               bus.out_wr = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         ST_SEND_ERR: begin
            bus.out_data = RSP_ERR;
            if (!bus.out_full) begin
               bus.out_wr = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_40mhz) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         res_q   <= 8'h00;
         hdr_q   <= 8'h00;
         start_q <= 1'b0;
`ifdef CMDFIFO_STATS_EN
         cnt_q   <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         res_q   <= res_d;
         hdr_q   <= hdr_d;
         start_q <= start_d;
`ifdef CMDFIFO_STATS_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cmdfifo_gcd_responder.sv
// Directed bench for cmdfifo_gcd_responder with FIFO models and an expected-byte scoreboard.
module tb_cmdfifo_gcd_responder;
   import cmdfifo_pkg::*;

   logic clk = 1'b0;
   logic reset_i = 1'b1;
   always #12.5 clk = ~clk;

   cmdfifo_gcd_responder_if bus();

   cmdfifo_gcd_responder #(.N(8)) dut (
      .clk_40mhz (clk),
      .reset_i   (reset_i),
      .bus       (bus)
   );

   logic [7:0] in_q[$];
   logic [7:0] exp_q[$];
   logic       full_force = 1'b0;
   int         n_vec = 0;
   int         n_err = 0;
   int         rd_cnt = 0;
   int         wr_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
      n_vec++;
   endtask

   task automatic push(input logic [7:0] b);
      in_q.push_back(b);
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_q.push_back(b);
   endtask

   task automatic wait_idle(input string tag);
      int cyc = 0;
      while ((in_q.size() != 0 || exp_q.size() != 0 || bus.busy) && cyc < 2000) begin
         @(negedge clk);
         #2;
         cyc++;
      end
      check({tag, "_timeout"}, 32'(cyc < 2000), 32'd1);
      check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
   endtask

   // FIFO models: drive on negedge, then sample the handshakes the DUT will act on at the next posedge
   always @(negedge clk) begin
      bus.in_empty = (in_q.size() == 0);
      bus.in_data  = (in_q.size() != 0) ? in_q[0] : 8'h00;
      bus.out_full = full_force;
      #1;
      if (!reset_i) begin
         if (bus.in_empty) check("rd_when_empty", 32'(bus.in_rd), 32'd0);
         else if (bus.in_rd) begin
            void'(in_q.pop_front());
            rd_cnt++;
         end
         if (bus.out_full) check("wr_when_full", 32'(bus.out_wr), 32'd0);
         else if (bus.out_wr) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("stray_byte", 32'(bus.out_data), 32'h100);
            else check("out_byte", 32'(bus.out_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      int calc_cyc;
      bus.in_empty = 1'b1;
      bus.in_data  = 8'h00;
      bus.out_full = 1'b0;
      reset_i = 1'b1;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      #2;
      check("rst_in_rd", 32'(bus.in_rd), 32'd0);
      check("rst_out_wr", 32'(bus.out_wr), 32'd0);
      check("rst_out_data", 32'(bus.out_data), 32'h00);
      check("rst_busy", 32'(bus.busy), 32'd0);

      // basic GCD(33,55)=11
      wr_cnt = 0;
      push(8'h47); push(8'h21); push(8'h37);
      expect_byte(8'h67); expect_byte(8'h0B);
      wait_idle("basic");
      check("basic_writes", 32'(wr_cnt), 32'd2);

      // unknown opcodes
      rd_cnt = 0; wr_cnt = 0;
      push(8'h41); push(8'h42); push(8'h43);
      expect_byte(8'h3F); expect_byte(8'h3F); expect_byte(8'h3F);
      wait_idle("unknown");
      check("unknown_rd_cnt", 32'(rd_cnt), 32'd3);
      check("unknown_writes", 32'(wr_cnt), 32'd3);

      // zero operands
      push(8'h47); push(8'h00); push(8'h00);
      expect_byte(8'h67); expect_byte(8'h00);
      wait_idle("gcd00");
      push(8'h47); push(8'h00); push(8'h09);
      expect_byte(8'h67); expect_byte(8'h09);
      wait_idle("gcd09");
      push(8'h47); push(8'h0A); push(8'h00);
      expect_byte(8'h67); expect_byte(8'h0A);
      wait_idle("gcd_x0");

      // worst-case CALC with outbound backpressure
      wr_cnt = 0;
      full_force = 1'b1;
      push(8'h47); push(8'hFF); push(8'h01);
      expect_byte(8'h67); expect_byte(8'h01);
      calc_cyc = 0;
      while (in_q.size() != 0 && calc_cyc < 100) begin @(negedge clk); calc_cyc++; end
      calc_cyc = 0;
      while (dut.state_q != ST_SEND_HDR && calc_cyc < 1000) begin @(negedge clk); calc_cyc++; end
      check("calc_len_le_512", 32'(calc_cyc <= 512), 32'd1);
      repeat (20) @(negedge clk);
      check("stall_no_writes", 32'(wr_cnt), 32'd0);
      full_force = 1'b0;
      wait_idle("worst");
      check("worst_writes", 32'(wr_cnt), 32'd2);

      // reset mid-command discards the partial command
      wr_cnt = 0;
      push(8'h47); push(8'h0C);
      calc_cyc = 0;
      while (in_q.size() != 0 && calc_cyc < 100) begin @(negedge clk); calc_cyc++; end
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      #2;
      check("post_rst_out_wr", 32'(bus.out_wr), 32'd0);
      check("post_rst_busy", 32'(bus.busy), 32'd0);
      push(8'h47); push(8'h0C); push(8'h12);
      expect_byte(8'h67); expect_byte(8'h06);
      wait_idle("rst_mid");
      repeat (5) @(negedge clk);
      check("rst_mid_writes", 32'(wr_cnt), 32'd2);

      // stats opcode
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
`ifdef CMDFIFO_STATS_EN
      push(8'h47); push(8'h08); push(8'h0C);
      expect_byte(8'h67); expect_byte(8'h04);
      push(8'h47); push(8'h07); push(8'h07);
      expect_byte(8'h67); expect_byte(8'h07);
      push(8'h53);
      expect_byte(8'h73); expect_byte(8'h02);
`else
      push(8'h53);
      expect_byte(8'h3F);
`endif
      wait_idle("stats");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
